// File: rtl/oled_byte_feeder.sv
// Byte queue feeding an OLED SPI stage: FIFO of {dc, byte}, request/done handshake, inter-byte gap.
// Define OLED_RESET_SEQ_EN to add a power-on OLED reset pulse before the first byte is sent.
module oled_byte_feeder #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned RST_CYCLES = 1200
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [7:0]               i_wr_data,
    input  logic                     i_wr_dc,
    input  logic                     i_wr_en,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic [7:0]               o_data,
    output logic                     o_data_ready,
    input  logic                     i_done,
    output logic                     o_dc,
    output logic                     o_oled_rst_n,
    output logic                     o_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [7:0]  GapLast = 8'(GAP_CYCLES - 1);

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two between 2 and 256");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("GAP_CYCLES must be between 1 and 255");
    end
    if (RST_CYCLES < 1) begin : g_bad_rst
        $error("RST_CYCLES must be at least 1");
    end

`ifdef OLED_RESET_SEQ_EN
    typedef enum logic [2:0] {StIdle, StSend, StRelease, StGap, StOledRst} state_e;
    localparam state_e StReset = StOledRst;
    localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0] RstLast = RW'(RST_CYCLES - 1);
`else
    typedef enum logic [1:0] {StIdle, StSend, StRelease, StGap} state_e;
    localparam state_e StReset = StIdle;
`endif

    // FIFO storage and bookkeeping
    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          push;
    logic          pop;
    logic [8:0]    head;

    // done synchronizer
    logic          done_meta_q;
    logic          done_s_q;

    // FSM and registered outputs
    state_e        state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          dc_q, dc_d;
    logic          ready_q, ready_d;
    logic [7:0]    gap_cnt_q, gap_cnt_d;
`ifdef OLED_RESET_SEQ_EN
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic          oled_rst_n_q, oled_rst_n_d;
`endif

    assign head = mem_q[rd_ptr_q];
    // A write into a full FIFO still lands when the head leaves in the same cycle.
    assign push = i_wr_en && (!full_q || pop);

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q + LW'(push) - LW'(pop);
        full_d     = (level_d == LW'(DEPTH));
        empty_d    = (level_d == '0);
        overflow_d = overflow_q | (i_wr_en & ~push);
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_wr_dc, i_wr_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            done_meta_q <= 1'b0;
            done_s_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            done_meta_q <= i_done;
            done_s_q    <= done_meta_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        dc_d         = dc_q;
        ready_d      = ready_q;
        gap_cnt_d    = gap_cnt_q;
        pop          = 1'b0;
`ifdef OLED_RESET_SEQ_EN
        rst_cnt_d    = rst_cnt_q;
        oled_rst_n_d = oled_rst_n_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    data_d  = head[7:0];
                    dc_d    = head[8];
                    state_d = StSend;
                end
            end
            StSend: begin
                // done only counts once the request is actually visible downstream
                if (ready_q && done_s_q) begin
                    ready_d = 1'b0;
                    state_d = StRelease;
                end else begin
                    ready_d = 1'b1;
                end
            end
            StRelease: begin
                ready_d = 1'b0;
                if (!done_s_q) begin
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    gap_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
`ifdef OLED_RESET_SEQ_EN
            StOledRst: begin
                if (rst_cnt_q == RstLast) begin
                    oled_rst_n_d = 1'b1;
                    state_d      = StIdle;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StReset;
            data_q       <= '0;
            dc_q         <= 1'b0;
            ready_q      <= 1'b0;
            gap_cnt_q    <= '0;
`ifdef OLED_RESET_SEQ_EN
            rst_cnt_q    <= '0;
            oled_rst_n_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            dc_q         <= dc_d;
            ready_q      <= ready_d;
            gap_cnt_q    <= gap_cnt_d;
`ifdef OLED_RESET_SEQ_EN
            rst_cnt_q    <= rst_cnt_d;
            oled_rst_n_q <= oled_rst_n_d;
`endif
        end
    end

    assign o_full       = full_q;
    assign o_empty      = empty_q;
    assign o_level      = level_q;
    assign o_overflow   = overflow_q;
    assign o_data       = data_q;
    assign o_dc         = dc_q;
    assign o_data_ready = ready_q;
    assign o_busy       = (state_q != StIdle) || !empty_q;
`ifdef OLED_RESET_SEQ_EN
    assign o_oled_rst_n = oled_rst_n_q;
`else
    assign o_oled_rst_n = 1'b1;
`endif

endmodule

// File: doc/oled_byte_feeder.md
OLED_BYTE_FEEDER -- requirements
Module: oled_byte_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 2 to 256.
REQ-002 Parameter GAP_CYCLES, default 4, minimum idle i_clk cycles between consecutive bytes; range 1 to 255.
REQ-003 Parameter RST_CYCLES, default 1200, length of the OLED reset pulse in i_clk cycles; used only when OLED_RESET_SEQ_EN is defined.
REQ-004 Ports, in this order:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous reset, active-low.
- i_wr_data  in  8  byte to queue.
- i_wr_dc  in  1  D/C tag for the byte (0 = command, 1 = data).
- i_wr_en  in  1  write strobe.
- o_full  out  1  FIFO full.
- o_empty  out  1  FIFO empty.
- o_level  out  clog2(DEPTH)+1  occupancy.
- o_overflow  out  1  sticky flag: a write was dropped.
- o_data  out  8  byte sent to the downstream SPI stage.
- o_data_ready  out  1  byte valid / transfer request.
- i_done  in  1  transfer complete, from the downstream SPI stage.
- o_dc  out  1  OLED D/C line.
- o_oled_rst_n  out  1  OLED reset line, active-low.
- o_busy  out  1  block active.

Function
REQ-005 i_wr_en with o_full low SHALL write {i_wr_dc, i_wr_data} at the tail.
- When full, a write SHALL still be accepted if a pop occurs in the same cycle.
- Otherwise the write SHALL be dropped and o_overflow SHALL set.
REQ-006 o_full, o_empty and o_level SHALL be registered and SHALL reflect all writes and pops of the previous edge; pointers wrap modulo DEPTH.
REQ-007 i_done SHALL pass through a 2-flop synchronizer (done_s) before any use.
REQ-008 State machine states: IDLE, SEND, RELEASE, GAP, plus OLED_RST when OLED_RESET_SEQ_EN is defined.
REQ-009 IDLE:
- If the FIFO is not empty, pop the head into o_data/o_dc and go to SEND.
- A write at edge N SHALL therefore yield a pop at edge N+1 and o_data_ready=1 after edge N+2.
REQ-010 SEND:
- o_data_ready=1; o_data and o_dc held stable.
- On done_s=1: o_data_ready=0 at the next edge, go to RELEASE.
REQ-011 RELEASE: o_data_ready=0; wait for done_s=0, then go to GAP.
REQ-012 GAP: count GAP_CYCLES cycles, then go to IDLE; no pop occurs during GAP.
REQ-013 o_dc SHALL hold its last popped value until the next pop.
REQ-014 o_busy SHALL be 1 whenever the state is not IDLE or o_empty=0.
REQ-015 done_s=1 observed in IDLE or GAP SHALL be ignored.
REQ-016 Exactly one pop occurs per SEND entry; bytes leave in write order.

Reset
REQ-017 Assertion of i_rst_n=0 SHALL asynchronously force:
- pointers 0, o_level=0, o_empty=1, o_full=0, o_overflow=0;
- o_data=0, o_dc=0, o_data_ready=0;
- synchronizer flops 0, GAP counter 0.
REQ-018 After reset, the state SHALL be IDLE, or OLED_RST with the macro defined; a reset mid-transfer discards all queued and in-flight bytes.
REQ-019 o_oled_rst_n SHALL reset to 0 with the macro defined and to 1 without it.

Configuration
REQ-020 Macro OLED_RESET_SEQ_EN.
- Defined: after reset, stay in OLED_RST with o_oled_rst_n=0 for RST_CYCLES cycles, then drive o_oled_rst_n=1 and enter IDLE. Writes are accepted during OLED_RST, but no pop occurs.
- Undefined: the OLED_RST state and its counter are absent, and o_oled_rst_n is tied to 1.

Verification
REQ-021 Write 0xAE (dc=0) into an empty FIFO at cycle 0 -> o_data=0xAE, o_dc=0, o_data_ready=1 from cycle 2; pulse i_done -> o_data_ready=0 two to three cycles after i_done rises.
REQ-022 Write 0x10, 0x20, 0x30 back-to-back -> three transfers in order; at least GAP_CYCLES cycles of o_data_ready=0 between them; i_done held high -> no second transfer until it falls.
REQ-023 Write 17 bytes with i_done held low (DEPTH=16) -> 1 pop, 16 stored, o_full=1, o_level=16; a further write -> dropped, o_overflow=1.
REQ-024 Drive i_rst_n=0 while in SEND with 5 queued -> o_data_ready=0, o_empty=1, o_level=0 immediately, without waiting for a clock edge.
REQ-025 With OLED_RESET_SEQ_EN defined and RST_CYCLES=8: o_oled_rst_n=0 for 8 cycles after reset; byte 0xAF written at cycle 2 -> no o_data_ready until after o_oled_rst_n rises.
REQ-026 Mixed dc pattern 0,1,1,0 -> o_dc matches each byte for its whole SEND/RELEASE window.
